// File: rtl/doom_mem_arbiter.sv
//------------------------------------------------------------------------------
// doom_mem_arbiter : two-requester round-robin Avalon-MM arbiter with lock.
// Optional completed-transfer counters enabled by `define MEM_ARB_STATS_EN.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module doom_mem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] i_m0_address,
  input  logic              i_m0_read,
  input  logic              i_m0_write,
  input  logic [DATA_W-1:0] i_m0_writedata,
  input  logic              i_m0_lock,
  output logic [DATA_W-1:0] o_m0_readdata,
  output logic              o_m0_waitrequest,
  input  logic [ADDR_W-1:0] i_m1_address,
  input  logic              i_m1_read,
  input  logic              i_m1_write,
  input  logic [DATA_W-1:0] i_m1_writedata,
  input  logic              i_m1_lock,
  output logic [DATA_W-1:0] o_m1_readdata,
  output logic              o_m1_waitrequest,
  output logic [ADDR_W-1:0] o_mem_address,
  output logic              o_mem_read,
  output logic              o_mem_write,
  output logic [DATA_W-1:0] o_mem_writedata,
  input  logic [DATA_W-1:0] i_mem_readdata,
  input  logic              i_mem_waitrequest,
  output logic [1:0]        o_grant
`ifdef MEM_ARB_STATS_EN
  ,
  output logic [31:0]       o_m0_xfer_count,
  output logic [31:0]       o_m1_xfer_count
`endif
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_GRANT0 = 2'd1,
    S_GRANT1 = 2'd2
  } state_t;

  state_t r_state;
  logic   r_last;

  logic w_req0;
  logic w_req1;
  logic w_own0;
  logic w_own1;
  logic w_done0;
  logic w_done1;

  assign w_req0  = i_m0_read | i_m0_write;
  assign w_req1  = i_m1_read | i_m1_write;
  assign w_own0  = (r_state == S_GRANT0);
  assign w_own1  = (r_state == S_GRANT1);
  assign w_done0 = w_own0 & w_req0 & ~i_mem_waitrequest;
  assign w_done1 = w_own1 & w_req1 & ~i_mem_waitrequest;

  // r_last starts at 1 so that m0 wins the first tie after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_last  <= 1'b1;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_req0 && w_req1) begin
            r_state <= r_last ? S_GRANT0 : S_GRANT1;
          end else if (w_req0) begin
            r_state <= S_GRANT0;
          end else if (w_req1) begin
            r_state <= S_GRANT1;
          end
        end
        S_GRANT0: begin
          if (w_done0) begin
            if (!i_m0_lock) begin
              r_state <= S_IDLE;
              r_last  <= 1'b0;
            end
          end else if (!w_req0 && !i_m0_lock) begin
            r_state <= S_IDLE;
          end
        end
        S_GRANT1: begin
          if (w_done1) begin
            if (!i_m1_lock) begin
              r_state <= S_IDLE;
              r_last  <= 1'b1;
            end
          end else if (!w_req1 && !i_m1_lock) begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_grant = {w_own1, w_own0};

  // A requester driving read and write together gets the write only.
  always_comb begin
    o_mem_address   = '0;
    o_mem_read      = 1'b0;
    o_mem_write     = 1'b0;
    o_mem_writedata = '0;
    if (w_own0) begin
      o_mem_address   = i_m0_address;
      o_mem_write     = i_m0_write;
      o_mem_read      = i_m0_read & ~i_m0_write;
      o_mem_writedata = i_m0_writedata;
    end else if (w_own1) begin
      o_mem_address   = i_m1_address;
      o_mem_write     = i_m1_write;
      o_mem_read      = i_m1_read & ~i_m1_write;
      o_mem_writedata = i_m1_writedata;
    end
  end

  assign o_m0_readdata    = i_mem_readdata;
  assign o_m1_readdata    = i_mem_readdata;
  assign o_m0_waitrequest = ~w_own0 | i_mem_waitrequest;
  assign o_m1_waitrequest = ~w_own1 | i_mem_waitrequest;

`ifdef MEM_ARB_STATS_EN
  logic [31:0] r_m0_cnt;
  logic [31:0] r_m1_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_m0_cnt <= '0;
      r_m1_cnt <= '0;
    end else begin
      if (w_done0) r_m0_cnt <= r_m0_cnt + 32'd1;
      if (w_done1) r_m1_cnt <= r_m1_cnt + 32'd1;
    end
  end

  assign o_m0_xfer_count = r_m0_cnt;
  assign o_m1_xfer_count = r_m1_cnt;
`endif

endmodule

`default_nettype wire

// File: tb/tb_doom_mem_arbiter.sv
//------------------------------------------------------------------------------
// tb_doom_mem_arbiter : directed vector table plus reset/stats sequences.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_doom_mem_arbiter;

  localparam logic [31:0] C_A0 = 32'hC000_0000;
  localparam logic [31:0] C_A1 = 32'h0000_1000;
  localparam logic [7:0]  C_D1 = 8'hA5;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] m0_address, m1_address;
  logic        m0_read, m0_write, m0_lock;
  logic        m1_read, m1_write, m1_lock;
  logic [7:0]  m0_writedata, m1_writedata;
  logic [7:0]  m0_readdata, m1_readdata;
  logic        m0_waitrequest, m1_waitrequest;
  logic [31:0] mem_address;
  logic        mem_read, mem_write;
  logic [7:0]  mem_writedata;
  logic [7:0]  mem_readdata;
  logic        mem_waitrequest;
  logic [1:0]  grant;
`ifdef MEM_ARB_STATS_EN
  logic [31:0] m0_xfer_count, m1_xfer_count;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  doom_mem_arbiter #(.ADDR_W(32), .DATA_W(8)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .i_m0_address     (m0_address),
    .i_m0_read        (m0_read),
    .i_m0_write       (m0_write),
    .i_m0_writedata   (m0_writedata),
    .i_m0_lock        (m0_lock),
    .o_m0_readdata    (m0_readdata),
    .o_m0_waitrequest (m0_waitrequest),
    .i_m1_address     (m1_address),
    .i_m1_read        (m1_read),
    .i_m1_write       (m1_write),
    .i_m1_writedata   (m1_writedata),
    .i_m1_lock        (m1_lock),
    .o_m1_readdata    (m1_readdata),
    .o_m1_waitrequest (m1_waitrequest),
    .o_mem_address    (mem_address),
    .o_mem_read       (mem_read),
    .o_mem_write      (mem_write),
    .o_mem_writedata  (mem_writedata),
    .i_mem_readdata   (mem_readdata),
    .i_mem_waitrequest(mem_waitrequest),
    .o_grant          (grant)
`ifdef MEM_ARB_STATS_EN
    ,
    .o_m0_xfer_count  (m0_xfer_count),
    .o_m1_xfer_count  (m1_xfer_count)
`endif
  );

  typedef struct {
    logic        r0, w0, l0;
    logic [7:0]  d0;
    logic        r1, w1, l1;
    logic        mw;
    logic [7:0]  mrd;
    logic [1:0]  g;
    logic        er, ew;
    logic [31:0] ea;
    logic [7:0]  ed;
    logic        w0q, w1q;
  } vec_t;

  vec_t vecs[$];

  task automatic v(input logic r0, w0, l0, input logic [7:0] d0,
                   input logic r1, w1, l1, input logic mw, input logic [7:0] mrd,
                   input logic [1:0] g, input logic er, ew,
                   input logic [31:0] ea, input logic [7:0] ed,
                   input logic w0q, w1q);
    vec_t t;
    t.r0 = r0; t.w0 = w0; t.l0 = l0; t.d0 = d0;
    t.r1 = r1; t.w1 = w1; t.l1 = l1;
    t.mw = mw; t.mrd = mrd;
    t.g = g; t.er = er; t.ew = ew; t.ea = ea; t.ed = ed;
    t.w0q = w0q; t.w1q = w1q;
    vecs.push_back(t);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    m0_read = 1'b0; m0_write = 1'b0; m0_lock = 1'b0; m0_writedata = 8'h00;
    m1_read = 1'b0; m1_write = 1'b0; m1_lock = 1'b0; m1_writedata = C_D1;
    mem_waitrequest = 1'b0; mem_readdata = 8'h00;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

`ifdef MEM_ARB_STATS_EN
  // One isolated single-cycle read by requester p.
  task automatic xfer(input int p);
    @(posedge clk); #1;
    if (p == 0) m0_read = 1'b1; else m1_read = 1'b1;
    @(posedge clk);
    @(posedge clk); #1;
    m0_read = 1'b0; m1_read = 1'b0;
  endtask
`endif

  initial begin
    m0_address = C_A0;
    m1_address = C_A1;
    idle_inputs();
    rst_n = 1'b0;
    #2;
    chk("rst_grant", {30'd0, grant}, 32'd0);
    chk("rst_m0_wait", {31'd0, m0_waitrequest}, 32'd1);
    chk("rst_m1_wait", {31'd0, m1_waitrequest}, 32'd1);
    chk("rst_mem_rw", {30'd0, mem_read, mem_write}, 32'd0);
    chk("rst_mem_addr", mem_address, 32'd0);
    do_reset();

    // r0 w0 l0 d0 | r1 w1 l1 | mw mrd | g er ew ea ed | w0q w1q
    v(0,0,0,8'h00, 0,0,0, 0,8'h00, 2'b00,0,0,32'd0,8'h00, 1,1);
    // Tie from reset: strict alternation m0, m1, ...
    for (int k = 0; k < 3; k++) begin
      v(1,0,0,8'h00, 1,0,0, 0,8'h5A, 2'b00,0,0,32'd0,8'h00, 1,1);
      v(1,0,0,8'h00, 1,0,0, 0,8'h5A, 2'b01,1,0,C_A0, 8'h00, 0,1);
      v(1,0,0,8'h00, 1,0,0, 0,8'h5A, 2'b00,0,0,32'd0,8'h00, 1,1);
      v(1,0,0,8'h00, 1,0,0, 0,8'h5A, 2'b10,1,0,C_A1, C_D1,  1,0);
    end
    v(0,0,0,8'h00, 0,0,0, 0,8'h00, 2'b00,0,0,32'd0,8'h00, 1,1);
    // Single read, latency 2
    v(1,0,0,8'h00, 0,0,0, 0,8'h03, 2'b00,0,0,32'd0,8'h00, 1,1);
    v(1,0,0,8'h00, 0,0,0, 0,8'h03, 2'b01,1,0,C_A0, 8'h00, 0,1);
    v(0,0,0,8'h00, 0,0,0, 0,8'h03, 2'b00,0,0,32'd0,8'h00, 1,1);
    // m1 read stalled three cycles
    v(0,0,0,8'h00, 1,0,0, 0,8'h00, 2'b00,0,0,32'd0,8'h00, 1,1);
    v(0,0,0,8'h00, 1,0,0, 1,8'h00, 2'b10,1,0,C_A1, C_D1,  1,1);
    v(0,0,0,8'h00, 1,0,0, 1,8'h00, 2'b10,1,0,C_A1, C_D1,  1,1);
    v(0,0,0,8'h00, 1,0,0, 1,8'h00, 2'b10,1,0,C_A1, C_D1,  1,1);
    v(0,0,0,8'h00, 1,0,0, 0,8'h77, 2'b10,1,0,C_A1, C_D1,  1,0);
    v(0,0,0,8'h00, 0,0,0, 0,8'h00, 2'b00,0,0,32'd0,8'h00, 1,1);
    // Locked m0 write burst while m1 waits
    v(0,1,1,8'h10, 1,0,0, 0,8'h00, 2'b00,0,0,32'd0,8'h00, 1,1);
    v(0,1,1,8'h10, 1,0,0, 0,8'h00, 2'b01,0,1,C_A0, 8'h10, 0,1);
    v(0,1,1,8'h11, 1,0,0, 0,8'h00, 2'b01,0,1,C_A0, 8'h11, 0,1);
    v(0,1,1,8'h12, 1,0,0, 0,8'h00, 2'b01,0,1,C_A0, 8'h12, 0,1);
    v(0,1,0,8'h13, 1,0,0, 0,8'h00, 2'b01,0,1,C_A0, 8'h13, 0,1);
    v(0,0,0,8'h00, 1,0,0, 0,8'h00, 2'b00,0,0,32'd0,8'h00, 1,1);
    v(0,0,0,8'h00, 1,0,0, 0,8'h00, 2'b10,1,0,C_A1, C_D1,  1,0);
    // m1 read+write: write wins
    v(0,0,0,8'h00, 1,1,0, 0,8'h00, 2'b00,0,0,32'd0,8'h00, 1,1);
    v(0,0,0,8'h00, 1,1,0, 0,8'h00, 2'b10,0,1,C_A1, C_D1,  1,0);
    v(0,0,0,8'h00, 0,0,0, 0,8'h00, 2'b00,0,0,32'd0,8'h00, 1,1);
    // m0 releases while stalled: IDLE, last stays m1, so m0 wins next tie
    v(1,0,0,8'h00, 0,0,0, 1,8'h00, 2'b00,0,0,32'd0,8'h00, 1,1);
    v(1,0,0,8'h00, 0,0,0, 1,8'h00, 2'b01,1,0,C_A0, 8'h00, 1,1);
    v(0,0,0,8'h00, 0,0,0, 1,8'h00, 2'b01,0,0,C_A0, 8'h00, 1,1);
    v(1,0,0,8'h00, 1,0,0, 0,8'h00, 2'b00,0,0,32'd0,8'h00, 1,1);
    v(1,0,0,8'h00, 1,0,0, 0,8'h00, 2'b01,1,0,C_A0, 8'h00, 0,1);
    v(0,0,0,8'h00, 0,0,0, 0,8'h00, 2'b00,0,0,32'd0,8'h00, 1,1);

    foreach (vecs[i]) begin
      @(posedge clk); #1;
      m0_read = vecs[i].r0; m0_write = vecs[i].w0; m0_lock = vecs[i].l0;
      m0_writedata = vecs[i].d0;
      m1_read = vecs[i].r1; m1_write = vecs[i].w1; m1_lock = vecs[i].l1;
      mem_waitrequest = vecs[i].mw; mem_readdata = vecs[i].mrd;
      @(negedge clk);
      chk($sformatf("v%0d_grant", i), {30'd0, grant}, {30'd0, vecs[i].g});
      chk($sformatf("v%0d_mem_read", i), {31'd0, mem_read}, {31'd0, vecs[i].er});
      chk($sformatf("v%0d_mem_write", i), {31'd0, mem_write}, {31'd0, vecs[i].ew});
      chk($sformatf("v%0d_mem_addr", i), mem_address, vecs[i].ea);
      chk($sformatf("v%0d_mem_wdata", i), {24'd0, mem_writedata}, {24'd0, vecs[i].ed});
      chk($sformatf("v%0d_m0_wait", i), {31'd0, m0_waitrequest}, {31'd0, vecs[i].w0q});
      chk($sformatf("v%0d_m1_wait", i), {31'd0, m1_waitrequest}, {31'd0, vecs[i].w1q});
      chk($sformatf("v%0d_m0_rdata", i), {24'd0, m0_readdata}, {24'd0, vecs[i].mrd});
      chk($sformatf("v%0d_m1_rdata", i), {24'd0, m1_readdata}, {24'd0, vecs[i].mrd});
    end

    // Asynchronous reset while m1 is stalled
    @(posedge clk); #1;
    idle_inputs();
    m1_read = 1'b1; mem_waitrequest = 1'b1;
    @(posedge clk); #1;
    chk("stall_grant", {30'd0, grant}, 32'd2);
    chk("stall_m1_wait", {31'd0, m1_waitrequest}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_grant", {30'd0, grant}, 32'd0);
    chk("arst_m0_wait", {31'd0, m0_waitrequest}, 32'd1);
    chk("arst_m1_wait", {31'd0, m1_waitrequest}, 32'd1);
    chk("arst_mem_read", {31'd0, mem_read}, 32'd0);
    idle_inputs();
    @(negedge clk);
    rst_n = 1'b1;

`ifdef MEM_ARB_STATS_EN
    do_reset();
    chk("cnt0_reset", m0_xfer_count, 32'd0);
    chk("cnt1_reset", m1_xfer_count, 32'd0);
    for (int k = 0; k < 5; k++) xfer(0);
    for (int k = 0; k < 2; k++) xfer(1);
    @(negedge clk);
    chk("cnt0_five", m0_xfer_count, 32'd5);
    chk("cnt1_two", m1_xfer_count, 32'd2);
    force dut.r_m1_cnt = 32'hFFFF_FFFF;
    #1;
    release dut.r_m1_cnt;
    xfer(1);
    @(negedge clk);
    chk("cnt1_wrap", m1_xfer_count, 32'd0);
    chk("cnt0_hold", m0_xfer_count, 32'd5);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/doom_mem_arbiter.md
# doom_mem_arbiter

Two-requester arbiter for the shared 8-bit Avalon-MM memory master used by the Doom accelerator handlers. The palette handler (requester 0) and the frame/blit handler (requester 1) each see a private Avalon-MM master port. The arbiter grants the single downstream `mem_*` port to one of them at a time, with round-robin fairness and an optional lock for back-to-back bursts. It sits between the handlers and the HPS–FPGA bridge memory port.

## Interface
Parameters:
- ADDR_W, 32, address width of all ports
- DATA_W, 8, data width of all ports

Ports:
- clk  in  1  system clock; all state on rising edge
- reset  in  1  asynchronous, active-low reset
- m0_address / m1_address  in  ADDR_W  requester address
- m0_read / m1_read  in  1  read request
- m0_write / m1_write  in  1  write request
- m0_writedata / m1_writedata  in  DATA_W  write data
- m0_lock / m1_lock  in  1  keep grant after current transfer
- m0_readdata / m1_readdata  out  DATA_W  read data
- m0_waitrequest / m1_waitrequest  out  1  Avalon stall to requester
- mem_address  out  ADDR_W  to shared memory
- mem_read, mem_write  out  1  to shared memory
- mem_writedata  out  DATA_W  to shared memory
- mem_readdata  in  DATA_W  from shared memory
- mem_waitrequest  in  1  from shared memory
- grant  out  2  one-hot current owner; 2'b00 when idle
- m0_xfer_count / m1_xfer_count  out  32  completed-transfer counters (only with MEM_ARB_STATS_EN)

## Operation
- Request: `mX_req = mX_read | mX_write`.
- Completion of a transfer: granted requester has req high and `mem_waitrequest == 0` in the same cycle.
- States: IDLE, GRANT0, GRANT1. Registered flag `last` records the last owner.
- IDLE transitions:
  - Only m0 requests -> GRANT0.
  - Only m1 requests -> GRANT1.
  - Both request -> grant the one that is not `last`.
  - Neither requests -> stay in IDLE.
- GRANTx transitions:
  - On completion with `mX_lock == 0` -> IDLE; `last <= x`.
  - On completion with `mX_lock == 1` -> stay in GRANTx.
  - If `mX_req == 0` and `mX_lock == 0` (requester released without a transfer) -> IDLE; `last` unchanged.
- Muxing (combinational from the registered state):
  - In GRANTx: `mem_*` outputs follow requester x.
  - In IDLE: `mem_read = mem_write = 0`, `mem_address = 0`, `mem_writedata = 0`.
- Read and write both asserted by a requester: write wins; `mem_read` is forced to 0 for that cycle.
- Readdata: `mem_readdata` is routed to both `mX_readdata` unconditionally. It is valid only for the owner, in its completion cycle.
- Waitrequest: `mX_waitrequest = ~(state == GRANTx) | mem_waitrequest`. A non-owner is always stalled, including in IDLE.

## Timing
- Reset values:
  - state = IDLE, `last = 1` (m0 wins the first tie), grant = 0.
  - All `mem_*` outputs 0; both `mX_waitrequest` = 1; counters 0.
- Arbitration latency: a request arriving in IDLE is granted at the next rising edge. The earliest completion is that same granted cycle, so the minimum read latency is 2 cycles.
- Unlocked back-to-back transfers from one requester incur a 1-cycle IDLE bubble between transfers.
- Locked transfers have no bubble; one transfer can complete per cycle.
- Under continuous contention with no lock, grants alternate strictly: m0, m1, m0, ...
- Lock dropped mid-stall: the change takes effect at the completion cycle. Only the lock value sampled in that cycle matters.
- Reset mid-transfer: returns to IDLE immediately (asynchronously). The in-flight transfer is abandoned, and the requester sees waitrequest = 1.

## Configuration
- `MEM_ARB_STATS_EN` defined:
  - `m0_xfer_count` and `m1_xfer_count` each increment by 1 on every completion by their requester.
  - 32-bit counters; wrap from 0xFFFFFFFF to 0; cleared by reset.
- Not defined: counter ports and logic are absent. Everything else is identical.

## Test plan
- Single read: m0_read with address 0xC0000000 at cycle 0, `mem_waitrequest = 0`, `mem_readdata = 0x03` -> grant = 01 at cycle 1; `mem_read = 1`, `mem_address = 0xC0000000`; `m0_waitrequest = 0` and `m0_readdata = 0x03` at cycle 1; back to IDLE at cycle 2.
- Tie: m0 and m1 both read from reset -> m0 is granted first, m1 next. With both held for 6 transfers -> grant sequence 01, 10, 01, 10, 01, 10.
- Stall: `mem_waitrequest` high for 3 cycles during the m1 grant -> `m1_waitrequest` = 1 for those 3 cycles; `m0_waitrequest` stays 1 throughout; grant stays 10.
- Lock: m0 does 4 writes (data 0x10–0x13) with `m0_lock = 1` while m1 requests -> 4 consecutive completions with no bubble; m1 is granted only after m0 drops lock on the 4th transfer.
- Read+write conflict and reset: m1 asserts both read and write -> `mem_write = 1`, `mem_read = 0`. Asserting reset low mid-stall -> grant = 00, waitrequests = 1 immediately.
- Stats (with `MEM_ARB_STATS_EN`): 5 m0 completions and 2 m1 completions -> counters read 5 and 2. Preloading a counter to 0xFFFFFFFF via force, then one more completion -> that counter reads 0.
